// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, store lane masks, link register.
// Also holds the registered load-control bundle that feeds the post-RAM extender.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [3:0] LANE_BYTE0   = 4'b0001;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_WORD    = 4'b1111;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic       vld;
        logic       uns;
        logic [1:0] size;
        logic [1:0] lane;
    } ld_ctrl_t;

endpackage

// File: rtl/data_memory.sv
// Dual-port synchronous data RAM: port A read/write with byte enables, port B read-only.
// 1-cycle read latency on both ports (read-before-write); en_a=0 holds port A read data.
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic [3:0]        we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [31:0]       wdata_a,
    output logic [31:0]       rdata_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [31:0]       rdata_b
);

    logic [31:0] mem [DEPTH];

    // Contents deliberately untouched by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_a[i]) begin
                mem[addr_a][i*8 +: 8] <= wdata_a[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            rdata_b <= mem[addr_b];
            if (en_a) begin
                rdata_a <= mem[addr_a];
            end
        end
    end

endmodule

// File: rtl/stage_memory.sv
// MIPS MEM stage with MEM/WB register: sized loads/stores, misalignment trap, debug read port.
// 1-cycle latency; i_enable=0 stalls every register and blocks writes (debug port keeps running).
module stage_memory
    import mem_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [31:0]       i_ALU_res,
    input  logic [31:0]       i_store_data,
    input  logic [4:0]        i_addr_reg_dst,
    input  logic [31:0]       i_pc_to_reg,
    input  logic              is_MemRead,
    input  logic              is_MemWrite,
    input  logic [1:0]        is_size,
    input  logic              is_unsigned,
    input  logic              is_RegWrite,
    input  logic              is_MemtoReg,
    input  logic              is_select_addr_reg,
    input  logic              is_write_pc,
    input  logic [ADDR_W-1:0] i_debug_addr,
    output logic [31:0]       o_output_mem,
    output logic [31:0]       o_ALU_res,
    output logic [4:0]        o_addr_reg_dst,
    output logic [31:0]       o_pc_to_reg,
    output logic              os_RegWrite,
    output logic              os_MemtoReg,
    output logic              os_select_addr_reg,
    output logic              os_write_pc,
    output logic              o_misaligned,
    output logic [31:0]       o_debug_data
);

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
        if (size[1])
            return LANE_WORD;
        else if (size == SZ_HALF)
            return lane[1] ? LANE_HALF_HI : LANE_HALF_LO;
        else
            return LANE_BYTE0 << lane;
    endfunction

    function automatic logic [31:0] store_steer(input logic [1:0] size, input logic [31:0] data);
        if (size[1])
            return data;
        else if (size == SZ_HALF)
            return {2{data[15:0]}};
        else
            return {4{data[7:0]}};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input ld_ctrl_t ctl);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ctl.lane, 3'b000} +: 8];
        h = ctl.lane[1] ? word[31:16] : word[15:0];
        if (ctl.size[1])
            return word;
        else if (ctl.size == SZ_HALF)
            return {{16{~ctl.uns & h[15]}}, h};
        else
            return {{24{~ctl.uns & b[7]}}, b};
    endfunction

    logic [1:0]  lane;
    logic        size_word;
    logic        size_half;
    logic        misaligned;
    logic        wr_ok;
    logic [31:0] rd_word;
    ld_ctrl_t    ld_q;

    assign lane      = i_ALU_res[1:0];
    // Encoding 2'b10 is treated as a word access too.
    assign size_word = is_size[1];
    assign size_half = (is_size == SZ_HALF);
    assign misaligned = (is_MemRead | is_MemWrite) &
                        ((size_half & lane[0]) | (size_word & (lane != 2'b00)));
    assign wr_ok     = i_reset & i_enable & is_MemWrite & ~misaligned;

    data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .en_a    (i_enable),
        .we_a    (store_mask(is_size, lane) & {4{wr_ok}}),
        .addr_a  (i_ALU_res[ADDR_W+1:2]),
        .wdata_a (store_steer(is_size, i_store_data)),
        .rdata_a (rd_word),
        .addr_b  (i_debug_addr),
        .rdata_b (o_debug_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ld_q               <= '0;
            o_ALU_res          <= '0;
            o_addr_reg_dst     <= '0;
            o_pc_to_reg        <= '0;
            os_RegWrite        <= 1'b0;
            os_MemtoReg        <= 1'b0;
            os_select_addr_reg <= 1'b0;
            os_write_pc        <= 1'b0;
            o_misaligned       <= 1'b0;
        end else if (i_enable) begin
            // A simultaneous read+write is honoured as a store only.
            ld_q.vld           <= is_MemRead & ~is_MemWrite & ~misaligned;
            ld_q.uns           <= is_unsigned;
            ld_q.size          <= is_size;
            ld_q.lane          <= lane;
            o_ALU_res          <= i_ALU_res;
            o_addr_reg_dst     <= i_addr_reg_dst;
            o_pc_to_reg        <= i_pc_to_reg;
            os_RegWrite        <= is_RegWrite & ~misaligned;
            os_MemtoReg        <= is_MemtoReg;
            os_select_addr_reg <= is_select_addr_reg;
            os_write_pc        <= is_write_pc;
            o_misaligned       <= misaligned;
        end
    end

    // Extension runs on registered RAM data and registered controls, so the result is stable all cycle.
    always_comb begin
        o_output_mem = '0;
        if (ld_q.vld) begin
            o_output_mem = load_extend(rd_word, ld_q);
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed scenarios plus randomized traffic against a byte-addressed model.
module tb_stage_memory;

    logic        i_clk = 1'b0;
    logic        i_reset, i_enable;
    logic [31:0] i_ALU_res, i_store_data, i_pc_to_reg;
    logic [4:0]  i_addr_reg_dst;
    logic        is_MemRead, is_MemWrite, is_unsigned;
    logic [1:0]  is_size;
    logic        is_RegWrite, is_MemtoReg, is_select_addr_reg, is_write_pc;
    logic [7:0]  i_debug_addr;
    logic [31:0] o_output_mem, o_ALU_res, o_pc_to_reg, o_debug_data;
    logic [4:0]  o_addr_reg_dst;
    logic        os_RegWrite, os_MemtoReg, os_select_addr_reg, os_write_pc, o_misaligned;

    int n_vec = 0;
    int n_err = 0;

    // Byte-addressed little-endian model memory (1 KiB window, addresses wrap).
    logic [7:0]  mb [1024];
    logic [31:0] e_mem, e_alu, e_pc, e_dbg;
    logic [4:0]  e_dst;
    logic        e_rw, e_m2r, e_sel, e_wpc, e_mis;

    stage_memory dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_ALU_res(i_ALU_res), .i_store_data(i_store_data),
        .i_addr_reg_dst(i_addr_reg_dst), .i_pc_to_reg(i_pc_to_reg),
        .is_MemRead(is_MemRead), .is_MemWrite(is_MemWrite), .is_size(is_size),
        .is_unsigned(is_unsigned), .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg),
        .is_select_addr_reg(is_select_addr_reg), .is_write_pc(is_write_pc),
        .i_debug_addr(i_debug_addr), .o_output_mem(o_output_mem), .o_ALU_res(o_ALU_res),
        .o_addr_reg_dst(o_addr_reg_dst), .o_pc_to_reg(o_pc_to_reg),
        .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg),
        .os_select_addr_reg(os_select_addr_reg), .os_write_pc(os_write_pc),
        .o_misaligned(o_misaligned), .o_debug_data(o_debug_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_word(input logic [9:0] base);
        logic [31:0] w;
        w = 0;
        for (int k = 0; k < 4; k++) w = w | (32'(mb[base + 10'(k)]) << (8 * k));
        return w;
    endfunction

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] data);
        is_MemRead = rd; is_MemWrite = wr; is_size = sz; is_unsigned = uns;
        i_ALU_res = addr; i_store_data = data;
        is_RegWrite = rd; is_MemtoReg = rd; is_select_addr_reg = 1'b0; is_write_pc = 1'b0;
        i_addr_reg_dst = 5'($urandom); i_pc_to_reg = $urandom;
    endtask

    // Computes what the outputs must show after the coming edge, updates the model, then advances.
    task automatic step();
        logic [9:0]  a;
        logic [31:0] v;
        int          n;
        logic        mis;
        if (!i_reset) begin
            {e_mem, e_alu, e_pc, e_dbg, e_dst} = '0;
            {e_rw, e_m2r, e_sel, e_wpc, e_mis} = '0;
        end else begin
            e_dbg = model_word({i_debug_addr, 2'b00});
            if (i_enable) begin
                a = i_ALU_res[9:0];
                n = (is_size == 2'b00) ? 1 : (is_size == 2'b01) ? 2 : 4;
                mis = (is_MemRead || is_MemWrite) && (int'(a) % n != 0);
                e_mis = mis; e_alu = i_ALU_res; e_dst = i_addr_reg_dst; e_pc = i_pc_to_reg;
                e_rw = is_RegWrite && !mis; e_m2r = is_MemtoReg;
                e_sel = is_select_addr_reg; e_wpc = is_write_pc;
                e_mem = 0;
                if (is_MemRead && !is_MemWrite && !mis) begin
                    v = 0;
                    for (int k = 0; k < n; k++) v = v | (32'(mb[a + 10'(k)]) << (8 * k));
                    if (!is_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                    e_mem = v;
                end
                if (is_MemWrite && !mis)
                    for (int k = 0; k < n; k++) mb[a + 10'(k)] = 8'(i_store_data >> (8 * k));
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic init_memory();
        i_reset = 1'b0; i_enable = 1'b1; i_debug_addr = '0;
        op(0, 0, 2'b11, 0, 0, 0);
        step(); step();
        i_reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            op(0, 1, 2'b11, 0, 32'(i * 4), $urandom);
            step();
        end
    endtask

    task automatic test_reset();
        logic [31:0] prior;
        prior = model_word(10'h010);
        i_reset = 1'b0; i_debug_addr = 8'd4;
        op(0, 1, 2'b11, 0, 32'h10, ~prior);
        is_RegWrite = 1'b1; is_write_pc = 1'b1;
        step(); step();
        n_vec++; if (o_output_mem !== 0) begin n_err++; $display("FAIL reset_mem: got %h want 0", o_output_mem); end
        n_vec++; if (o_ALU_res !== 0) begin n_err++; $display("FAIL reset_alu: got %h want 0", o_ALU_res); end
        n_vec++; if ({os_RegWrite, os_MemtoReg, os_select_addr_reg, os_write_pc, o_misaligned} !== 5'b0)
            begin n_err++; $display("FAIL reset_ctrl: got %b want 00000", {os_RegWrite, os_MemtoReg, os_select_addr_reg, os_write_pc, o_misaligned}); end
        n_vec++; if (o_debug_data !== 0) begin n_err++; $display("FAIL reset_dbg: got %h want 0", o_debug_data); end
        i_reset = 1'b1;
        op(0, 0, 2'b11, 0, 0, 0);
        step();
        n_vec++; if (o_debug_data !== prior) begin n_err++; $display("FAIL reset_mem_kept: got %h want %h", o_debug_data, prior); end
    endtask

    task automatic test_word();
        op(0, 1, 2'b11, 0, 32'h20, 32'hDEADBEEF); step();
        op(1, 0, 2'b11, 0, 32'h20, 0); step();
        n_vec++; if (o_output_mem !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_load: got %h want deadbeef", o_output_mem); end
        n_vec++; if (os_RegWrite !== 1'b1 || os_MemtoReg !== 1'b1) begin n_err++; $display("FAIL word_ctrl: got %b%b want 11", os_RegWrite, os_MemtoReg); end
    endtask

    task automatic test_sizing();
        op(0, 1, 2'b00, 0, 32'h21, 32'h0000_0080); step();
        op(1, 0, 2'b00, 0, 32'h21, 0); step();
        n_vec++; if (o_output_mem !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb: got %h want ffffff80", o_output_mem); end
        op(1, 0, 2'b00, 1, 32'h21, 0); step();
        n_vec++; if (o_output_mem !== 32'h00000080) begin n_err++; $display("FAIL lbu: got %h want 00000080", o_output_mem); end
        op(0, 1, 2'b11, 0, 32'h20, 32'h11223344); step();
        op(0, 1, 2'b01, 0, 32'h22, 32'hAAAA_8001); step();
        op(1, 0, 2'b11, 0, 32'h20, 0); step();
        n_vec++; if (o_output_mem !== 32'h80013344) begin n_err++; $display("FAIL sh_lw: got %h want 80013344", o_output_mem); end
        op(1, 0, 2'b01, 0, 32'h22, 0); step();
        n_vec++; if (o_output_mem !== 32'hFFFF8001) begin n_err++; $display("FAIL lh: got %h want ffff8001", o_output_mem); end
    endtask

    task automatic test_misaligned();
        op(0, 1, 2'b11, 0, 32'h23, 32'h0BAD_0BAD); step();
        n_vec++; if (o_misaligned !== 1'b1) begin n_err++; $display("FAIL mis_sw_flag: got %b want 1", o_misaligned); end
        op(1, 0, 2'b11, 0, 32'h20, 0); step();
        n_vec++; if (o_output_mem !== 32'h80013344) begin n_err++; $display("FAIL mis_sw_nowrite: got %h want 80013344", o_output_mem); end
        n_vec++; if (o_misaligned !== 1'b0) begin n_err++; $display("FAIL aligned_flag: got %b want 0", o_misaligned); end
        op(1, 0, 2'b01, 0, 32'h21, 0); step();
        n_vec++; if (o_output_mem !== 0 || os_RegWrite !== 1'b0 || o_misaligned !== 1'b1)
            begin n_err++; $display("FAIL mis_lh: got mem=%h rw=%b mis=%b want 0/0/1", o_output_mem, os_RegWrite, o_misaligned); end
    endtask

    task automatic test_stall();
        i_debug_addr = 8'd12;
        op(0, 1, 2'b11, 0, 32'h30, 32'h12345678); step();
        op(1, 0, 2'b11, 0, 32'h40, 0); step();
        i_enable = 1'b0;
        op(0, 1, 2'b11, 0, 32'h30, 32'h55AA55AA);
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++; if (o_ALU_res !== 32'h40 || o_debug_data !== 32'h12345678)
                begin n_err++; $display("FAIL stall_hold[%0d]: got alu=%h dbg=%h want 00000040/12345678", c, o_ALU_res, o_debug_data); end
        end
        i_enable = 1'b1;
        step();
        n_vec++; if (o_ALU_res !== 32'h30 || o_debug_data !== 32'h12345678)
            begin n_err++; $display("FAIL stall_release: got alu=%h dbg=%h want 00000030/12345678", o_ALU_res, o_debug_data); end
        op(0, 0, 2'b11, 0, 32'h44, 0); step();
        n_vec++; if (o_debug_data !== 32'h55AA55AA) begin n_err++; $display("FAIL stall_commit: got %h want 55aa55aa", o_debug_data); end
    endtask

    task automatic test_jal();
        op(0, 0, 2'b00, 0, 32'h1234, 0);
        is_RegWrite = 1'b1; is_write_pc = 1'b1; is_select_addr_reg = 1'b1;
        i_pc_to_reg = 32'h0000004C; i_addr_reg_dst = mem_pkg::REG_RA;
        step();
        n_vec++; if (o_pc_to_reg !== 32'h4C || o_addr_reg_dst !== 5'd31)
            begin n_err++; $display("FAIL jal_pc: got pc=%h dst=%0d want 0000004c/31", o_pc_to_reg, o_addr_reg_dst); end
        n_vec++; if (os_write_pc !== 1'b1 || os_select_addr_reg !== 1'b1 || os_RegWrite !== 1'b1 || o_output_mem !== 0)
            begin n_err++; $display("FAIL jal_ctrl: got wpc=%b sel=%b rw=%b mem=%h want 1/1/1/0", os_write_pc, os_select_addr_reg, os_RegWrite, o_output_mem); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] old;
        i_debug_addr = 8'h10;
        old = model_word(10'h040);
        op(0, 1, 2'b11, 0, 32'h40, ~old); step();
        n_vec++; if (o_debug_data !== old) begin n_err++; $display("FAIL dbg_same_cycle: got %h want %h", o_debug_data, old); end
        op(1, 1, 2'b11, 0, 32'h40, 32'hFEEDC0DE); step();
        n_vec++; if (o_debug_data !== ~old || o_output_mem !== 0)
            begin n_err++; $display("FAIL rw_both: got dbg=%h mem=%h want %h/0", o_debug_data, o_output_mem, ~old); end
        op(1, 0, 2'b11, 0, 32'h40, 0); step();
        n_vec++; if (o_output_mem !== 32'hFEEDC0DE) begin n_err++; $display("FAIL rw_both_store: got %h want feedc0de", o_output_mem); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int c = 0; c < 600; c++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[9:4] = 6'h05;
            op(1'($urandom), 1'($urandom_range(2) == 0), 2'($urandom), 1'($urandom), a, $urandom);
            is_RegWrite = 1'($urandom); is_MemtoReg = 1'($urandom);
            is_select_addr_reg = 1'($urandom); is_write_pc = 1'($urandom);
            i_debug_addr = ($urandom_range(1) == 0) ? 8'h05 << 2 : 8'($urandom);
            i_enable = ($urandom_range(99) < 85);
            i_reset  = ($urandom_range(99) >= 3);
            step();
            n_vec++; if (o_output_mem !== e_mem) begin n_err++; $display("FAIL rnd_mem[%0d]: got %h want %h", c, o_output_mem, e_mem); end
            n_vec++; if (o_ALU_res !== e_alu) begin n_err++; $display("FAIL rnd_alu[%0d]: got %h want %h", c, o_ALU_res, e_alu); end
            n_vec++; if (o_addr_reg_dst !== e_dst) begin n_err++; $display("FAIL rnd_dst[%0d]: got %0d want %0d", c, o_addr_reg_dst, e_dst); end
            n_vec++; if (o_pc_to_reg !== e_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, o_pc_to_reg, e_pc); end
            n_vec++; if ({os_RegWrite, os_MemtoReg, os_select_addr_reg, os_write_pc} !== {e_rw, e_m2r, e_sel, e_wpc})
                begin n_err++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", c, {os_RegWrite, os_MemtoReg, os_select_addr_reg, os_write_pc}, {e_rw, e_m2r, e_sel, e_wpc}); end
            n_vec++; if (o_misaligned !== e_mis) begin n_err++; $display("FAIL rnd_mis[%0d]: got %b want %b", c, o_misaligned, e_mis); end
            n_vec++; if (o_debug_data !== e_dbg) begin n_err++; $display("FAIL rnd_dbg[%0d]: got %h want %h", c, o_debug_data, e_dbg); end
        end
        i_reset = 1'b1; i_enable = 1'b1;
    endtask

    initial begin
        init_memory();
        test_reset();
        test_word();
        test_sizing();
        test_misaligned();
        test_stall();
        test_jal();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM latch and Stage_WriteBack.
- Performs data-memory loads and stores with byte/half/word sizing and sign/zero extension.
- Contains the MEM/WB pipeline register. Its registered outputs drive Stage_WriteBack directly.
- Has a one-cycle debug read port into data memory for the debug unit.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory.
- ADDR_W, 8, word-index width; must equal log2(DEPTH).

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous reset, active-low
- i_enable  in  1  pipeline advance; 0 = hold all state, no memory write
- i_ALU_res  in  32  byte address for load/store; passthrough result otherwise
- i_store_data  in  32  rt value to store
- i_addr_reg_dst  in  5  destination register
- i_pc_to_reg  in  32  PC+8 for jal/jalr
- is_MemRead  in  1  load
- is_MemWrite  in  1  store
- is_size  in  2  00 byte, 01 half, 11 word (10 = word)
- is_unsigned  in  1  zero-extend loads (lbu/lhu)
- is_RegWrite, is_MemtoReg, is_select_addr_reg, is_write_pc  in  1 each  WB controls, passed through
- i_debug_addr  in  ADDR_W  debug word index
- o_output_mem  out  32  extended load data
- o_ALU_res  out  32  registered i_ALU_res
- o_addr_reg_dst  out  5  registered
- o_pc_to_reg  out  32  registered
- os_RegWrite, os_MemtoReg, os_select_addr_reg, os_write_pc  out  1 each  registered controls
- o_misaligned  out  1  registered flag for the access just latched
- o_debug_data  out  32  word at i_debug_addr, 1-cycle latency

Behaviour:
- Reset (i_reset=0 at an edge):
  - All outputs go to 0, including o_debug_data.
  - Memory contents are not cleared.
  - A store presented in the reset cycle is suppressed.
- Word index = i_ALU_res[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Latency is 1 cycle. All outputs are registered. Inputs at edge N appear at the outputs after edge N.
  - Load data comes from the synchronous RAM read at edge N, then is lane-selected and extended combinationally before the output register.
  - Implementation may either register RAM output and extend after, or extend before registering. Externally visible latency must be 1.
- i_enable=0: every output register and the memory hold. Debug port still updates.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - o_misaligned=1.
  - Store is suppressed.
  - Load returns 0.
  - os_RegWrite is forced to 0 for that instruction.
- Store byte enables:
  - byte: lane = addr[1:0]; data[7:0] replicated to that lane.
  - half: lanes {1,0} if addr[1]=0, else {3,2}; data[15:0] placed accordingly.
  - word: all lanes.
  - Lane 0 = bits [7:0], little-endian.
- Load extract:
  - byte: lane addr[1:0]; sign-extend bit 7 unless is_unsigned.
  - half: per addr[1]; sign-extend bit 15 unless is_unsigned.
  - word: as stored.
- When is_MemRead=0, o_output_mem = 0.
- is_MemRead and is_MemWrite both 1 is illegal. Required behaviour: the store executes, o_output_mem = 0.
- Back-to-back store then load to the same word: the load sees the new data (write at edge N, read at edge N+1).
- Debug read of a word written in the same cycle returns the old value.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11;
  - lane mask constants;
  - REG_RA=5'd31.
- Sub-module data_memory:
  - dual-port synchronous RAM;
  - port A: read/write, 4-bit byte enable;
  - port B: read-only, for debug;
  - DEPTH/ADDR_W parameters.
- Store lane-steering and load extension stay as functions inside stage_memory.

Test Plan:
- Reset: hold i_reset=0 two cycles with is_MemWrite=1, addr 0x10 -> all outputs 0; then debug read of word 4 shows its prior contents unchanged.
- Word store/load: SW 0xDEADBEEF at 0x20, next cycle LW 0x20 with MemtoReg=1, RegWrite=1 -> o_output_mem=0xDEADBEEF one cycle later; os_RegWrite=1.
- Byte/half sizing:
  - SB 0x80 to 0x21, then LB 0x21 -> 0xFFFFFF80; LBU -> 0x00000080.
  - SH 0x8001 to 0x22 over word 0x11223344, then LW -> 0x80013344; LH 0x22 -> 0xFFFF8001.
- Misaligned: SW at 0x23 -> o_misaligned=1 and memory unchanged; LH at 0x21 -> o_output_mem=0, os_RegWrite=0.
- Stall: i_enable=0 for 3 cycles during a SW -> outputs frozen, no write; on release the store commits exactly once.
- jal passthrough: is_write_pc=1, is_select_addr_reg=1, i_pc_to_reg=0x0000004C -> same values on outputs next cycle; o_output_mem=0.
